// File: rtl/button_press_arbiter.sv
// Shared debounce sampler and round-robin press arbiter for a bank of
// pushbuttons. One tick divider paces a two-stage sampler per button; each
// released->pressed transition raises a pending flag, and pending presses are
// handed out one at a time over a valid/ready handshake.
module button_press_arbiter #(
  parameter int N_BTN    = 4,
  parameter int ID_W     = 2,
  parameter int TICK_DIV = 250000
) (
  input  logic             in_clk,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] buttons,
  output logic             press_valid,
  output logic [ID_W-1:0]  press_id,
  input  logic             press_ready,
  output logic             press_dropped
);

  localparam int              CNT_W    = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N_BTN - 1);
  localparam logic [N_BTN-1:0] BTN_ONE  = {{(N_BTN-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] tick_cnt;
  logic             tick;
  logic             tick_d;
  logic [N_BTN-1:0] s1;
  logic [N_BTN-1:0] s2;
  logic [N_BTN-1:0] press_evt;
  logic [N_BTN-1:0] pending;
  logic [N_BTN-1:0] grant_vec;
  logic [N_BTN-1:0] granted;
  logic [N_BTN-1:0] rot;
  logic [ID_W-1:0]  grant_idx;
  logic [ID_W-1:0]  last_grant;
  logic             grant_any;
  logic             slot_free;
  logic             do_grant;
  logic             drop;
  int               cand;

  assign tick = (tick_cnt == CNT_LAST);

  // Sample-tick divider: free-running 0..TICK_DIV-1, plus a delayed tick
  // that marks the cycle in which freshly sampled levels are compared.
  always_ff @(posedge in_clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
      tick_d   <= 1'b0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      tick_d   <= tick;
    end
  end

  // Two sample stages per button, advanced only on tick; s1 doubles as the
  // synchronizer for the raw asynchronous levels.
  always_ff @(posedge in_clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
    end else if (tick) begin
      s1 <= buttons;
      s2 <= s1;
    end
  end

  // Rising edge between consecutive samples, seen once per tick period.
  assign press_evt = {N_BTN{tick_d}} & s1 & ~s2;

  // Round-robin scan starting just after the last granted button.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    grant_vec = '0;
    cand      = 0;
    rot       = '0;
    for (int k = 1; k <= N_BTN; k++) begin
      cand = (int'(last_grant) + k) % N_BTN;
      rot  = pending >> cand;
      if (!grant_any && rot[0]) begin
        grant_any = 1'b1;
        grant_idx = ID_W'(cand);
        grant_vec = BTN_ONE << cand;
      end
    end
  end

  assign slot_free = ~press_valid | press_ready;
  assign do_grant  = slot_free & grant_any;
  assign granted   = do_grant ? grant_vec : '0;
  // A new edge on a button whose earlier press is still waiting (and is not
  // leaving this cycle) merges into the same flag and is reported as lost.
  assign drop      = |(press_evt & pending & ~granted);

  // Pending flags: a same-cycle event re-arms a button that is being granted.
  always_ff @(posedge in_clk or negedge reset_n) begin
    if (!reset_n) begin
      pending       <= '0;
      press_dropped <= 1'b0;
    end else begin
      pending       <= (pending & ~granted) | press_evt;
      press_dropped <= drop;
    end
  end

  // Output slot: load a new grant whenever the slot is empty or draining.
  always_ff @(posedge in_clk or negedge reset_n) begin
    if (!reset_n) begin
      press_valid <= 1'b0;
      press_id    <= '0;
      last_grant  <= ID_LAST;
    end else if (slot_free) begin
      if (do_grant) begin
        press_valid <= 1'b1;
        press_id    <= grant_idx;
        last_grant  <= grant_idx;
      end else begin
        press_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_button_press_arbiter.sv
// Bench for button_press_arbiter with a short tick divider. Expected press
// ids are queued as buttons are driven and popped on every handshake; each
// scenario task also checks its own cycle-exact timing.
module tb_button_press_arbiter;

  localparam int N_BTN    = 4;
  localparam int ID_W     = 2;
  localparam int TICK_DIV = 4;

  logic             in_clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [N_BTN-1:0] buttons = '0;
  logic             press_ready = 1'b0;
  logic             press_valid;
  logic [ID_W-1:0]  press_id;
  logic             press_dropped;

  int errors = 0;
  int checks = 0;
  int hs_cnt = 0;
  int drop_cnt = 0;
  int mcnt = 0;
  logic [ID_W-1:0] exp_q[$];
  logic [ID_W-1:0] sb_exp;

  button_press_arbiter #(.N_BTN(N_BTN), .ID_W(ID_W), .TICK_DIV(TICK_DIV)) dut (
    .in_clk(in_clk),
    .reset_n(reset_n),
    .buttons(buttons),
    .press_valid(press_valid),
    .press_id(press_id),
    .press_ready(press_ready),
    .press_dropped(press_dropped)
  );

  always #5 in_clk = ~in_clk;

  // Reference tick divider: value seen during the current cycle.
  always @(posedge in_clk or negedge reset_n) begin
    if (!reset_n) mcnt <= 0;
    else mcnt <= (mcnt == TICK_DIV - 1) ? 0 : mcnt + 1;
  end

  // Scoreboard monitor: every handshake must match the head of the queue.
  always begin
    @(negedge in_clk);
    #2;
    if (reset_n) begin
      if (press_dropped) drop_cnt++;
      if (press_valid && press_ready) begin
        hs_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got press_id=%0d, expected no press", press_id);
        end else begin
          sb_exp = exp_q.pop_front();
          if (press_id !== sb_exp) begin
            errors++;
            $display("FAIL sb_order: got press_id=%0d, expected %0d", press_id, sb_exp);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic cyc();
    @(negedge in_clk);
    #1;
  endtask

  task automatic wait_tick();
    int n = 0;
    do begin
      cyc();
      n++;
    end while (mcnt != TICK_DIV - 1 && n < 3 * TICK_DIV);
    if (mcnt != TICK_DIV - 1) begin
      checks++;
      errors++;
      $display("FAIL wait_tick: got mcnt=%0d, expected %0d", mcnt, TICK_DIV - 1);
    end
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    buttons = '0;
    exp_q.delete();
    repeat (3) cyc();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    int bad_v = 0;
    int bad_d = 0;
    reset_n = 1'b0;
    buttons = 4'b1111;
    press_ready = 1'b1;
    repeat (3) cyc();
    checks++;
    if (press_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, expected 0", press_valid); end
    checks++;
    if (press_id !== 2'd0) begin errors++; $display("FAIL rst_id: got %0d, expected 0", press_id); end
    checks++;
    if (press_dropped !== 1'b0) begin errors++; $display("FAIL rst_dropped: got %b, expected 0", press_dropped); end
    reset_n = 1'b1;
    buttons = '0;
    for (int k = 0; k < 40; k++) begin
      cyc();
      if (press_valid !== 1'b0) bad_v++;
      if (press_dropped !== 1'b0) bad_d++;
    end
    checks++;
    if (bad_v != 0) begin errors++; $display("FAIL idle_valid: got %0d valid cycles, expected 0", bad_v); end
    checks++;
    if (bad_d != 0) begin errors++; $display("FAIL idle_dropped: got %0d drop cycles, expected 0", bad_d); end
  endtask

  task automatic test_single();
    int first = -1;
    int nv = 0;
    int nrel = 0;
    int hs0;
    logic [ID_W-1:0] got_id = '0;
    press_ready = 1'b1;
    hs0 = hs_cnt;
    wait_tick();
    buttons = 4'b0100;
    exp_q.push_back(2'd2);
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (press_valid === 1'b1) begin
        nv++;
        if (first < 0) begin
          first = k;
          got_id = press_id;
        end
      end
    end
    checks++;
    if (first != 3) begin errors++; $display("FAIL single_latency: got first valid at T+%0d, expected T+3", first); end
    checks++;
    if (nv != 1) begin errors++; $display("FAIL single_count: got %0d valid cycles, expected 1", nv); end
    checks++;
    if (got_id !== 2'd2) begin errors++; $display("FAIL single_id: got %0d, expected 2", got_id); end
    buttons = '0;
    for (int k = 0; k < 12; k++) begin
      cyc();
      if (press_valid === 1'b1) nrel++;
    end
    checks++;
    if (nrel != 0) begin errors++; $display("FAIL single_release: got %0d valid cycles, expected 0", nrel); end
    checks++;
    if (hs_cnt - hs0 != 1) begin errors++; $display("FAIL single_hs: got %0d handshakes, expected 1", hs_cnt - hs0); end
  endtask

  task automatic test_bounce();
    int hs0;
    press_ready = 1'b1;
    hs0 = hs_cnt;
    wait_tick();
    for (int k = 0; k < TICK_DIV - 1; k++) begin
      cyc();
      buttons[1] = ~buttons[1];
    end
    buttons[1] = 1'b1;
    exp_q.push_back(2'd1);
    repeat (20) cyc();
    buttons = '0;
    repeat (12) cyc();
    checks++;
    if (hs_cnt - hs0 != 1) begin errors++; $display("FAIL bounce_hs: got %0d handshakes, expected 1", hs_cnt - hs0); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL bounce_queue: got %0d undelivered, expected 0", exp_q.size()); end
  endtask

  task automatic rr_burst(input logic [4*ID_W-1:0] order);
    logic [ID_W-1:0] e;
    press_ready = 1'b1;
    wait_tick();
    buttons = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      e = order[k*ID_W +: ID_W];
      exp_q.push_back(e);
    end
    cyc();
    cyc();
    checks++;
    if (press_valid !== 1'b0) begin errors++; $display("FAIL rr_early: got valid=%b at T+2, expected 0", press_valid); end
    for (int k = 0; k < 4; k++) begin
      cyc();
      e = order[k*ID_W +: ID_W];
      checks++;
      if (press_valid !== 1'b1 || press_id !== e) begin
        errors++;
        $display("FAIL rr_seq%0d: got valid=%b id=%0d, expected valid=1 id=%0d", k, press_valid, press_id, e);
      end
    end
    cyc();
    checks++;
    if (press_valid !== 1'b0) begin errors++; $display("FAIL rr_tail: got valid=%b, expected 0", press_valid); end
    buttons = '0;
    repeat (12) cyc();
  endtask

  task automatic test_round_robin();
    apply_reset();
    rr_burst({2'd3, 2'd2, 2'd1, 2'd0});
    wait_tick();
    buttons = 4'b0010;
    exp_q.push_back(2'd1);
    repeat (10) cyc();
    buttons = '0;
    repeat (12) cyc();
    rr_burst({2'd1, 2'd0, 2'd3, 2'd2});
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rr_queue: got %0d undelivered, expected 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    int unstable = 0;
    press_ready = 1'b0;
    wait_tick();
    buttons = 4'b1001;
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd0);
    repeat (3) cyc();
    checks++;
    if (press_valid !== 1'b1 || press_id !== 2'd3) begin
      errors++;
      $display("FAIL bp_first: got valid=%b id=%0d, expected valid=1 id=3", press_valid, press_id);
    end
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (press_valid !== 1'b1 || press_id !== 2'd3) unstable++;
    end
    checks++;
    if (unstable != 0) begin errors++; $display("FAIL bp_hold: got %0d unstable cycles, expected 0", unstable); end
    press_ready = 1'b1;
    cyc();
    checks++;
    if (press_valid !== 1'b1 || press_id !== 2'd0) begin
      errors++;
      $display("FAIL bp_next: got valid=%b id=%0d, expected valid=1 id=0", press_valid, press_id);
    end
    cyc();
    checks++;
    if (press_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got valid=%b, expected 0", press_valid); end
    buttons = '0;
    repeat (12) cyc();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL bp_queue: got %0d undelivered, expected 0", exp_q.size()); end
  endtask

  task automatic test_drop();
    int d0;
    int hs0;
    press_ready = 1'b0;
    d0 = drop_cnt;
    wait_tick();
    buttons = 4'b0100;
    exp_q.push_back(2'd2);
    repeat (TICK_DIV) cyc();
    buttons = 4'b0101;
    exp_q.push_back(2'd0);
    repeat (TICK_DIV) cyc();
    buttons = 4'b0100;
    repeat (TICK_DIV) cyc();
    buttons = 4'b0101;
    repeat (8) cyc();
    checks++;
    if (drop_cnt - d0 != 1) begin errors++; $display("FAIL drop_pulse: got %0d drop cycles, expected 1", drop_cnt - d0); end
    checks++;
    if (press_valid !== 1'b1 || press_id !== 2'd2) begin
      errors++;
      $display("FAIL drop_hold: got valid=%b id=%0d, expected valid=1 id=2", press_valid, press_id);
    end
    hs0 = hs_cnt;
    press_ready = 1'b1;
    repeat (6) cyc();
    checks++;
    if (hs_cnt - hs0 != 2) begin errors++; $display("FAIL drop_hs: got %0d handshakes, expected 2", hs_cnt - hs0); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL drop_queue: got %0d undelivered, expected 0", exp_q.size()); end
    buttons = '0;
    repeat (12) cyc();
  endtask

  task automatic test_collision();
    int d0;
    press_ready = 1'b0;
    d0 = drop_cnt;
    wait_tick();
    buttons = 4'b0010;
    exp_q.push_back(2'd1);
    repeat (TICK_DIV) cyc();
    buttons = 4'b0011;
    exp_q.push_back(2'd0);
    repeat (TICK_DIV) cyc();
    buttons = 4'b0010;
    repeat (TICK_DIV) cyc();
    buttons = 4'b0011;
    cyc();
    checks++;
    if (press_valid !== 1'b1 || press_id !== 2'd1) begin
      errors++;
      $display("FAIL col_hold: got valid=%b id=%0d, expected valid=1 id=1", press_valid, press_id);
    end
    press_ready = 1'b1;
    exp_q.push_back(2'd0);
    cyc();
    checks++;
    if (press_valid !== 1'b1 || press_id !== 2'd0) begin
      errors++;
      $display("FAIL col_first: got valid=%b id=%0d, expected valid=1 id=0", press_valid, press_id);
    end
    cyc();
    checks++;
    if (press_valid !== 1'b1 || press_id !== 2'd0) begin
      errors++;
      $display("FAIL col_again: got valid=%b id=%0d, expected valid=1 id=0", press_valid, press_id);
    end
    cyc();
    checks++;
    if (press_valid !== 1'b0) begin errors++; $display("FAIL col_empty: got valid=%b, expected 0", press_valid); end
    repeat (4) cyc();
    checks++;
    if (drop_cnt - d0 != 0) begin errors++; $display("FAIL col_nodrop: got %0d drop cycles, expected 0", drop_cnt - d0); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL col_queue: got %0d undelivered, expected 0", exp_q.size()); end
    buttons = '0;
    repeat (12) cyc();
  endtask

  task automatic test_reset_mid();
    int nv = 0;
    press_ready = 1'b0;
    wait_tick();
    buttons = 4'b1010;
    repeat (4) cyc();
    reset_n = 1'b0;
    buttons = '0;
    exp_q.delete();
    cyc();
    checks++;
    if (press_valid !== 1'b0 || press_id !== 2'd0) begin
      errors++;
      $display("FAIL midrst_out: got valid=%b id=%0d, expected valid=0 id=0", press_valid, press_id);
    end
    cyc();
    reset_n = 1'b1;
    press_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (press_valid === 1'b1) nv++;
    end
    checks++;
    if (nv != 0) begin errors++; $display("FAIL midrst_discard: got %0d valid cycles, expected 0", nv); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_bounce();
    test_round_robin();
    test_backpressure();
    test_drop();
    test_collision();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/button_press_arbiter.md
Name: button_press_arbiter

Overview:
Shares one debounce sampling engine among N_BTN game pushbuttons and hands debounced presses to the game FSM one at a time. The block has an internal sample-tick divider on in_clk, and each button has two sample stages. Each button that goes from released to pressed gives exactly one press event. A round-robin arbiter queues these events and delivers them over a valid/ready handshake. It replaces per-button debouncer plus slow-clock pairs and runs entirely in the in_clk domain, with no derived clocks.

Parameters:
N_BTN, 4, number of pushbuttons (2..16)
ID_W, 2, width of press_id; must satisfy 2**ID_W >= N_BTN
TICK_DIV, 250000, in_clk cycles per sample tick (>= 2)

Ports:
in_clk  input  1  system clock; all state on rising edge
reset_n  input  1  asynchronous, active-low reset
buttons  input  N_BTN  raw asynchronous pushbutton levels, 1 = pressed
press_valid  output  1  a press is presented on press_id
press_id  output  ID_W  index of the button whose press is presented
press_ready  input  1  consumer accepts the press when press_valid & press_ready
press_dropped  output  1  one-cycle pulse: a new press collided with an undelivered press of the same button

Behaviour:
- Reset (reset_n low, asynchronous): all of the following clear immediately and stay cleared while reset_n is low.
  - Outputs: press_valid=0, press_id=0, press_dropped=0.
  - Internal state: tick counter=0, tick_d=0, s1=s2=0, pending=0, last_grant=N_BTN-1, so the first search starts at button 0.
  - Reset mid-operation discards any held or pending presses.
- Tick counter:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - tick=1 for exactly the one cycle in which the counter equals TICK_DIV-1.
  - tick_d is tick registered by one cycle.
- Sampling: on each tick cycle, s1<=buttons and s2<=s1. Otherwise s1 and s2 hold.
- Event detection:
  - event[i] = tick_d & s1[i] & ~s2[i], which is at most one cycle per tick period.
  - A held button produces no further events.
  - Release produces no event.
- Pending flags:
  - event[i] sets pending[i] at the end of the cycle.
  - A grant of button i clears pending[i].
  - If event[i] and a grant of i occur in the same cycle, pending[i] ends at 1 and there is no drop.
  - If event[i] occurs while pending[i]=1 and i is not granted that cycle, pending stays 1 and press_dropped pulses high for one cycle. Several simultaneous drops still give a single pulse.
- Output slot:
  - "Free" means press_valid=0, or press_valid & press_ready in this cycle.
  - When the slot is free and any pending bit is set, grant the first set index scanning last_grant+1, last_grant+2, ... modulo N_BTN.
  - On a grant, at the end of the cycle: press_valid<=1, press_id<=index, last_grant<=index, pending[index]<=0.
  - When the slot is free and no pending bit is set, press_valid<=0.
  - Back-to-back: a handshake and a new grant in the same cycle keep press_valid high with the new press_id.
  - While press_valid=1 and press_ready=0, press_id and press_valid hold stable. Pending bits keep accumulating.
- Latency: for a press sampled at tick cycle T, pending is set at the end of T+1. press_valid=1 first appears in cycle T+3, provided the slot is free and there is no competing pending press.
- Fairness: with all buttons persistently pending and press_ready=1, grants cycle 0,1,...,N_BTN-1,0,...; no button waits more than N_BTN grants.
- press_id values >= N_BTN are never produced.

Test Plan:
- Reset/idle: TICK_DIV=4, hold reset_n=0 for 3 cycles with buttons=4'b1111. Release reset with buttons=0 -> press_valid=0, press_dropped=0 for 40 cycles.
- Single press latency: TICK_DIV=4, press_ready=1, raise buttons[2] before tick cycle T and hold it for 20 cycles.
  - press_valid=1 with press_id=2 for exactly one cycle, at T+3.
  - No second press while the button is held.
  - Releasing the button gives no press.
- Bounce rejection: toggle buttons[1] every in_clk cycle between two ticks, then hold it at 1 -> exactly one press with press_id=1.
- Round-robin: buttons=4'b1111 rise before one tick and press_ready=1 -> press_id sequence 0,1,2,3 on four consecutive cycles.
  - Re-run with last_grant=1 (first deliver a press for button 1 only, release all buttons, wait ≥2 ticks) -> next simultaneous all-button press delivers order 2,3,0,1.
- Backpressure hold: press_ready=0 with press_valid=1 and press_id=3 for 10 cycles -> press_valid and press_id stay stable.
  - Raise press_ready -> handshake, then the next pending press appears on the following cycle with no bubble.
- Drop and collision:
  - Setup: press_ready=0 with button 0 pending and not granted. Release and re-press button 0 across two ticks -> press_dropped pulses for one cycle and pending[0] stays 1.
  - Collision: arrange event[0] in the same cycle that button 0 is granted -> no press_dropped, and press_id=0 is delivered again afterwards.
